// File: rtl/alu_sched_pkg.sv
// Shared definitions for the round-robin ALU scheduler: opcodes, FSM encoding, datapath width.
package alu_sched_pkg;

    localparam int ALU_W = 32;

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_AND    = 4'd2;
    localparam logic [3:0] OP_OR     = 4'd3;
    localparam logic [3:0] OP_XOR    = 4'd4;
    localparam logic [3:0] OP_NOT    = 4'd5;
    localparam logic [3:0] OP_LSHIFT = 4'd6;
    localparam logic [3:0] OP_RSHIFT = 4'd7;
    localparam logic [3:0] OP_MUL    = 4'd8;
    localparam logic [3:0] OP_MOVA   = 4'd9;
    localparam logic [3:0] OP_MOVB   = 4'd10;
    localparam logic [3:0] OP_LAST   = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_rr_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first valid requester searching upward from last_grant+1, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req_valid,
    input  logic [ID_W-1:0]    i_last_grant,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_grant_idx,
    output logic               o_any_valid
);

    logic [ID_W-1:0] w_cand;
    logic            w_found;

    // k runs 1..NUM_REQ so the previous winner is examined last
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = ID_W'((int'(i_last_grant) + k) % NUM_REQ);
            if (!w_found && i_req_valid[w_cand]) begin
                w_found         = 1'b1;
                o_grant_idx     = w_cand;
                o_grant[w_cand] = 1'b1;
            end
        end
    end

    assign o_any_valid = |i_req_valid;

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one external combinational ALU among NUM_REQ requesters (IDLE -> EXEC -> RESP).
// Optional macro ALU_SCHED_OPCHK_EN: illegal opcodes run as MOVA and return resp_err=1, result 0.
module alu_rr_scheduler
    import alu_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [4*NUM_REQ-1:0]     req_op,
    input  logic [ALU_W*NUM_REQ-1:0] req_a,
    input  logic [ALU_W*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [ALU_W-1:0]         alu_a,
    output logic [ALU_W-1:0]         alu_b,
    output logic [3:0]               alu_op,
    input  logic [ALU_W-1:0]         alu_y,
    input  logic                     alu_carry,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ALU_W-1:0]         resp_y,
    output logic                     resp_carry,
    output logic [ID_W-1:0]          resp_id,
    output logic                     resp_err
);

    logic [NUM_REQ-1:0][3:0]       w_op_arr;
    logic [NUM_REQ-1:0][ALU_W-1:0] w_a_arr;
    logic [NUM_REQ-1:0][ALU_W-1:0] w_b_arr;
    logic [NUM_REQ-1:0]            w_grant;
    logic [ID_W-1:0]               w_idx;
    logic                          w_any;
    logic [3:0]                    w_op_sel;

    state_t          r_state;
    logic [ID_W-1:0] r_last_grant;
    logic [ALU_W-1:0] r_alu_a, r_alu_b, r_resp_y;
    logic [3:0]      r_alu_op;
    logic            r_resp_valid, r_resp_carry;
    logic [ID_W-1:0] r_resp_id;

    assign w_op_arr = req_op;
    assign w_a_arr  = req_a;
    assign w_b_arr  = req_b;
    assign w_op_sel = w_op_arr[w_idx];

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .i_req_valid  (req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_grant_idx  (w_idx),
        .o_any_valid  (w_any)
    );

    // Accept is a combinational offer; only IDLE can take a new operation
    assign req_ready = (r_state == ST_IDLE) ? w_grant : '0;

`ifdef ALU_SCHED_OPCHK_EN
    logic r_bad, r_err;
    assign resp_err = r_err;
`else
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= ID_W'(NUM_REQ - 1);
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_resp_valid <= 1'b0;
            r_resp_y     <= '0;
            r_resp_carry <= 1'b0;
            r_resp_id    <= '0;
`ifdef ALU_SCHED_OPCHK_EN
            r_bad        <= 1'b0;
            r_err        <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: if (w_any) begin
                    r_alu_a      <= w_a_arr[w_idx];
                    r_alu_b      <= w_b_arr[w_idx];
`ifdef ALU_SCHED_OPCHK_EN
                    r_alu_op     <= (w_op_sel > OP_LAST) ? OP_MOVA : w_op_sel;
                    r_bad        <= (w_op_sel > OP_LAST);
`else
                    r_alu_op     <= w_op_sel;
`endif
                    r_resp_id    <= w_idx;
                    r_last_grant <= w_idx;
                    r_state      <= ST_EXEC;
                end
                ST_EXEC: begin
`ifdef ALU_SCHED_OPCHK_EN
                    r_resp_y     <= r_bad ? '0 : alu_y;
                    r_resp_carry <= !r_bad && alu_carry;
                    r_err        <= r_bad;
`else
                    r_resp_y     <= alu_y;
                    r_resp_carry <= alu_carry;
`endif
                    r_resp_valid <= 1'b1;
                    r_state      <= ST_RESP;
                end
                ST_RESP: if (resp_ready) begin
                    r_resp_valid <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_op     = r_alu_op;
    assign resp_valid = r_resp_valid;
    assign resp_y     = r_resp_y;
    assign resp_carry = r_resp_carry;
    assign resp_id    = r_resp_id;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler with a behavioural top_alu stand-in (opcode 11..15 -> DEADBEEF).
module tb_alu_rr_scheduler;

    localparam int N = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [N-1:0]        req_valid = '0;
    logic [N-1:0][3:0]   req_op = '0;
    logic [N-1:0][31:0]  req_a = '0;
    logic [N-1:0][31:0]  req_b = '0;
    logic [N-1:0]        req_ready;
    logic [31:0]         alu_a, alu_b, alu_y, resp_y;
    logic [3:0]          alu_op;
    logic                alu_carry, resp_valid, resp_carry, resp_err;
    logic                resp_ready = 1'b0;
    logic [1:0]          resp_id;
    logic [32:0]         sum;

    int checks = 0, errors = 0, cyc = 0, last_acc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_rr_scheduler #(.NUM_REQ(N), .ID_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y), .alu_carry(alu_carry),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_y(resp_y),
        .resp_carry(resp_carry), .resp_id(resp_id), .resp_err(resp_err)
    );

    // stand-in for the external top_alu; SUB carry is the borrow
    always_comb begin
        alu_y = 32'hDEAD_BEEF;
        alu_carry = 1'b0;
        sum = '0;
        case (alu_op)
            4'd0:  begin sum = {1'b0, alu_a} + {1'b0, alu_b}; alu_y = sum[31:0]; alu_carry = sum[32]; end
            4'd1:  begin alu_y = alu_a - alu_b; alu_carry = (alu_a < alu_b); end
            4'd2:  alu_y = alu_a & alu_b;
            4'd3:  alu_y = alu_a | alu_b;
            4'd4:  alu_y = alu_a ^ alu_b;
            4'd5:  alu_y = ~alu_a;
            4'd6:  alu_y = alu_a << alu_b[4:0];
            4'd7:  alu_y = alu_a >> alu_b[4:0];
            4'd8:  alu_y = alu_a * alu_b;
            4'd9:  alu_y = alu_a;
            4'd10: alu_y = alu_b;
            default: ;
        endcase
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    // One transaction: wait for grant, check EXEC, check response, optionally stall, handshake.
    task automatic run_txn(input int id, input logic [3:0] eop, input logic [31:0] ey,
                           input logic ec, input logic ee, input int hold,
                           input logic drop, input logic gap);
        bit got = 0;
        for (int t = 0; t < 20; t++) begin
            #1;
            if (|req_ready) begin got = 1; break; end
            @(negedge clk);
        end
        chk("grant_seen", 64'(got), 64'd1);
        if (!got) return;
        chk("grant", 64'(req_ready), 64'(1) << id);
        if (gap) chk("accept_gap", 64'(cyc - last_acc), 64'd3);
        last_acc = cyc;
        @(posedge clk);
        #1;
        if (drop) req_valid[id] = 1'b0;
        @(negedge clk);
        chk("exec_resp_valid", 64'(resp_valid), 64'd0);
        chk("exec_req_ready", 64'(req_ready), 64'd0);
        chk("alu_op", 64'(alu_op), 64'(eop));
        @(negedge clk);
        chk("resp_valid", 64'(resp_valid), 64'd1);
        chk("resp_y", 64'(resp_y), 64'(ey));
        chk("resp_carry", 64'(resp_carry), 64'(ec));
        chk("resp_id", 64'(resp_id), 64'(id));
        chk("resp_err", 64'(resp_err), 64'(ee));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 64'(resp_valid), 64'd1);
            chk("hold_y", 64'(resp_y), 64'(ey));
            chk("hold_carry", 64'(resp_carry), 64'(ec));
            chk("hold_req_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    typedef struct {
        int          id;
        logic [3:0]  op;
        logic [31:0] a, b, y;
        logic        c;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{1, 4'd0,  32'd56, 32'd32, 32'd88,         1'b0};
        tbl[1]  = '{0, 4'd1,  32'd56, 32'd32, 32'd24,         1'b0};
        tbl[2]  = '{2, 4'd8,  32'd56, 32'd32, 32'd1792,       1'b0};
        tbl[3]  = '{3, 4'd2,  32'd56, 32'd32, 32'd32,         1'b0};
        tbl[4]  = '{1, 4'd3,  32'd56, 32'd32, 32'd56,         1'b0};
        tbl[5]  = '{2, 4'd4,  32'd56, 32'd32, 32'd24,         1'b0};
        tbl[6]  = '{0, 4'd5,  32'd56, 32'd32, 32'hFFFF_FFC7,  1'b0};
        tbl[7]  = '{3, 4'd6,  32'd56, 32'd1,  32'd112,        1'b0};
        tbl[8]  = '{1, 4'd7,  32'd56, 32'd3,  32'd7,          1'b0};
        tbl[9]  = '{2, 4'd9,  32'd56, 32'd32, 32'd56,         1'b0};
        tbl[10] = '{0, 4'd10, 32'd56, 32'd32, 32'd32,         1'b0};
        tbl[11] = '{3, 4'd1,  32'd32, 32'd56, 32'hFFFF_FFE8,  1'b1};

        // reset state
        #12;
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_alu_a", 64'(alu_a), 64'd0);
        chk("rst_alu_op", 64'(alu_op), 64'd0);
        chk("rst_resp_y", 64'(resp_y), 64'd0);
        chk("rst_resp_id", 64'(resp_id), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // single-requester vectors, one opcode each
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            req_valid = '0;
            req_valid[tbl[i].id] = 1'b1;
            req_op[tbl[i].id] = tbl[i].op;
            req_a[tbl[i].id]  = tbl[i].a;
            req_b[tbl[i].id]  = tbl[i].b;
            run_txn(tbl[i].id, tbl[i].op, tbl[i].y, tbl[i].c, 1'b0, 0, 1'b1, 1'b0);
        end

        // 0, 2, 3 all pending: round-robin order, back-to-back accepts
        do_reset();
        @(negedge clk);
        req_op[0] = 4'd1; req_a[0] = 32'd56; req_b[0] = 32'd32;
        req_op[2] = 4'd8; req_a[2] = 32'd56; req_b[2] = 32'd32;
        req_op[3] = 4'd2; req_a[3] = 32'd56; req_b[3] = 32'd32;
        req_valid = 4'b1101;
        run_txn(0, 4'd1, 32'd24,   1'b0, 1'b0, 0, 1'b1, 1'b0);
        run_txn(2, 4'd8, 32'd1792, 1'b0, 1'b0, 0, 1'b1, 1'b1);
        run_txn(3, 4'd2, 32'd32,   1'b0, 1'b0, 0, 1'b1, 1'b1);

        // overflow add with response back-pressure, then the waiting requester
        req_op[1] = 4'd0; req_a[1] = 32'hFFFF_FFFF; req_b[1] = 32'd1;
        req_op[3] = 4'd4; req_a[3] = 32'd56;        req_b[3] = 32'd32;
        req_valid = 4'b1010;
        run_txn(1, 4'd0, 32'd0,  1'b1, 1'b0, 5, 1'b1, 1'b0);
        run_txn(3, 4'd4, 32'd24, 1'b0, 1'b0, 0, 1'b1, 1'b0);

        // illegal opcode
        req_op[1] = 4'd12; req_a[1] = 32'd56; req_b[1] = 32'd32;
        req_valid = 4'b0010;
`ifdef ALU_SCHED_OPCHK_EN
        run_txn(1, 4'd9, 32'd0, 1'b0, 1'b1, 0, 1'b1, 1'b0);
`else
        run_txn(1, 4'd12, 32'hDEAD_BEEF, 1'b0, 1'b0, 0, 1'b1, 1'b0);
`endif

        // reset while in EXEC
        req_op[2] = 4'd0; req_a[2] = 32'd1; req_b[2] = 32'd2;
        req_valid = 4'b0100;
        #1;
        chk("pre_abort_grant", 64'(req_ready), 64'b0100);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_resp_valid", 64'(resp_valid), 64'd0);
        chk("abort_alu_a", 64'(alu_a), 64'd0);
        chk("abort_alu_b", 64'(alu_b), 64'd0);
        chk("abort_alu_op", 64'(alu_op), 64'd0);
        chk("abort_resp_y", 64'(resp_y), 64'd0);
        chk("abort_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_abort_no_resp", 64'(resp_valid), 64'd0);

        // all four continuously valid: 0,1,2,3,0,1,2,3
        for (int r = 0; r < N; r++) begin
            req_op[r] = 4'd0; req_a[r] = 32'(r); req_b[r] = 32'd10;
        end
        req_valid = '1;
        for (int i = 0; i < 8; i++)
            run_txn(i % N, 4'd0, 32'(10 + i % N), 1'b0, 1'b0, 0, 1'b0, i > 0);
        req_valid = '0;

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
